// File: rtl/inst_writer.sv
// Instruction writer: accepts decoded instruction fields, encodes 16-bit words and
// writes them sequentially into instruction memory. Optional running XOR checksum
// is enabled by defining INST_WRITER_CSUM_EN.
module inst_writer #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [1:0]  in_rd,
  input  logic [1:0]  in_ra,
  input  logic [1:0]  in_rb,
  input  logic [7:0]  in_imm,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic [8:0]  count,
  output logic        full,
  output logic        done,
  output logic        err,
  output logic [15:0] csum
);

  localparam int unsigned CW = 9;
  localparam int unsigned WW = 16;
  localparam logic [WW-1:0] HLT_WORD = 16'hC000;

  typedef enum logic [1:0] {IDLE, RUN, WRITE, STOP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic            legal;
  logic [WW-1:0]   enc_word;
  logic [CW-1:0]   count_inc;
  logic            last_word;
  logic            hlt_written;

  assign accept      = in_valid && in_ready;
  assign count_inc   = count + CW'(1);
  assign hlt_written = (mem_wdata == HLT_WORD);
  assign last_word   = (count_inc == CW'(DEPTH));

  // Write strobe is gated by rst so a reset landing on the WRITE cycle kills the write.
  assign mem_we = (state == WRITE) && !rst;

  // Opcode decode and word encoding; unlisted bits stay zero.
  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (in_op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4:
        enc_word = {in_op, 2'b00, in_rd, 2'b00, in_ra, 2'b00, in_rb};
      4'h5:
        enc_word = {in_op, 2'b00, in_rd, 2'b00, in_ra, 4'b0000};
      4'hA, 4'hB:
        enc_word = {in_op, 2'b00, in_rd, 8'h00};
      4'h8, 4'hE:
        enc_word = {in_op, 2'b00, in_rd, in_imm};
      4'hF:
        enc_word = {in_op, 4'b0000, in_imm};
      4'hC:
        enc_word = HLT_WORD;
      default:
        legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, STOP: if (start) state_nxt = RUN;
      RUN:        if (accept && legal) state_nxt = WRITE;
      WRITE:      state_nxt = (hlt_written || last_word) ? STOP : RUN;
      default:    state_nxt = IDLE;
    endcase
  end

  // Registered outputs and write-port payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      full      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      in_ready <= (state_nxt == RUN);
      case (state)
        IDLE, STOP: begin
          if (start) begin
            count <= '0;
            full  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            if (legal) begin
              mem_addr  <= count[7:0];
              mem_wdata <= enc_word;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          count <= count_inc;
          if (hlt_written) done <= 1'b1;
          if (last_word)   full <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef INST_WRITER_CSUM_EN
  // Running XOR over every word committed to memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
    end else if ((state == IDLE || state == STOP) && start) begin
      csum <= '0;
    end else if (state == WRITE) begin
      csum <= csum ^ mem_wdata;
    end
  end
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_inst_writer.sv
// Randomized scoreboard bench for inst_writer against a behavioural program-writer model.
module tb_inst_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [1:0]  in_rd;
  logic [1:0]  in_ra;
  logic [1:0]  in_rb;
  logic [7:0]  in_imm;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [8:0]  count;
  logic        full;
  logic        done;
  logic        err;
  logic [15:0] csum;

  inst_writer #(.DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .done(done), .err(err), .csum(csum)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: program being written and its status.
  int          m_count;
  bit          m_done, m_err, m_full, m_run;
  logic [15:0] m_csum;
  logic [23:0] exp_q[$];

  function automatic logic [15:0] model_word(int op, int rd, int ra, int rb, int imm);
    int w;
    w = op * 4096;
    case (op)
      0, 1, 2, 3, 4: w += rd * 256 + ra * 16 + rb;
      5:             w += rd * 256 + ra * 16;
      10, 11:        w += rd * 256;
      8, 14:         w += rd * 256 + imm;
      15:            w += imm;
      default:       ;
    endcase
    return 16'(w);
  endfunction

  function automatic bit model_legal(int op);
    return !(op == 6 || op == 7 || op == 9 || op == 13);
  endfunction

  function automatic int exp_csum();
`ifdef INST_WRITER_CSUM_EN
    return int'(m_csum);
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_count = 0; m_done = 0; m_err = 0; m_full = 0; m_csum = '0;
  endtask

  // Scoreboard monitor: every write must match the oldest expected word.
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("wr_addr", int'(mem_addr), int'(e[23:16]));
        check("wr_data", int'(mem_wdata), int'(e[15:0]));
      end
    end
  end

  task automatic send(input int op, input int rd, input int ra, input int rb,
                      input int imm, input bit track);
    int waitc;
    logic [15:0] w;
    waitc = 0;
    @(negedge clk);
    in_op = 4'(op); in_rd = 2'(rd); in_ra = 2'(ra); in_rb = 2'(rb); in_imm = 8'(imm);
    in_valid = 1'b1;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (!track) return;
    if (model_legal(op)) begin
      w = model_word(op, rd, ra, rb, imm);
      exp_q.push_back({8'(m_count), w});
      m_csum ^= w;
      m_count++;
      if (op == 12) begin
        m_done = 1; m_run = 0;
      end else if (m_count == 256) begin
        m_full = 1; m_run = 0;
      end
    end else begin
      m_err = 1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, int'(count), m_count);
    check({tag, "_err"}, int'(err), int'(m_err));
    check({tag, "_done"}, int'(done), int'(m_done));
    check({tag, "_full"}, int'(full), int'(m_full));
    check({tag, "_ready"}, int'(in_ready), int'(m_run));
    check({tag, "_csum"}, int'(csum), exp_csum());
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_we"}, int'(mem_we), 0);
    check({tag, "_addr"}, int'(mem_addr), 0);
    check({tag, "_wdata"}, int'(mem_wdata), 0);
    check_status(tag);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (!m_run) begin
      model_clear();
      m_run = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_clear();
    m_run = 0;
    exp_q.delete();
    check_reset("reset");
    rst = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_op = '0; in_rd = '0; in_ra = '0; in_rb = '0; in_imm = '0;
    model_clear();
    m_run = 0;
    do_reset();

    // Single LOAD, then start is ignored while running.
    do_start();
    check_status("started");
    send(8, 2, 0, 0, 8'h5A, 1'b1);
    settle();
    check_status("load");
    do_start();
    check_status("start_in_run");

    // ADD then JNZ from a fresh program.
    do_reset();
    do_start();
    send(0, 1, 2, 3, 0, 1'b1);
    send(14, 3, 0, 0, 8'h04, 1'b1);
    settle();
    check_status("add_jnz");

    // Illegal opcode, then INC, then HLT and restart.
    send(7, 1, 1, 1, 8'hFF, 1'b1);
    settle();
    check_status("illegal");
    send(10, 1, 3, 3, 8'hAA, 1'b1);
    settle();
    check_status("inc");
    send(12, 3, 3, 3, 8'hFF, 1'b1);
    settle();
    check_status("hlt");
    do_start();
    check_status("restart");

    // Randomized instruction stream; restart whenever the program stops.
    repeat (60) begin
      int op;
      op = int'($urandom_range(0, 15));
      if (op == 12 && $urandom_range(0, 3) != 0) op = 10;
      if (!m_run) do_start();
      send(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1'b1);
      settle();
      check_status("rand");
    end

    // Fill the whole memory with INC rd=0.
    do_reset();
    do_start();
    for (int i = 0; i < 256; i++) send(10, 0, 0, 0, 0, 1'b1);
    settle();
    check_status("fill");

    // Reset landing on the WRITE cycle.
    do_start();
    send(1, 2, 1, 3, 0, 1'b1);
    settle();
    send(4, 3, 2, 1, 0, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_write_we", int'(mem_we), 0);
    @(posedge clk);
    #1;
    model_clear();
    m_run = 0;
    check_reset("rst_write");
    rst = 1'b0;
    settle();

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_writer.md
INST_WRITER -- requirements
Module: inst_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of instruction-memory words (power of two, max 256).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  begin a new program at address 0.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, forming the instruction-field handshake; transfer occurs when both are high on a rising edge.
REQ-006 SHALL have ports in_op input 4 (opcode), in_rd input 2 (destination), in_ra input 2 (source A), in_rb input 2 (source B), and in_imm input 8 (immediate or jump target).
REQ-007 SHALL have ports mem_we output 1, mem_addr output 8 and mem_wdata output 16, forming the instruction-memory write port.
REQ-008 SHALL have ports count output 9 (words written), full output 1, done output 1 (HLT written) and err output 1 (sticky illegal opcode).
REQ-009 SHALL have port csum output 16, the running XOR of written words (see Configuration).

Function
REQ-010 SHALL implement states IDLE, RUN, WRITE and STOP; in_ready SHALL be high only in RUN.
REQ-011 SHALL transition IDLE->RUN and STOP->RUN on start=1, clearing count, done, err and csum; start SHALL be ignored in RUN and WRITE.
REQ-012 SHALL, on an accepted legal opcode in RUN, register the encoded word and enter WRITE; mem_we SHALL be high for exactly that one WRITE cycle with mem_addr=count[7:0], after which count increments (write latency: 1 cycle after accept; throughput: 1 word per 2 cycles).
REQ-013 SHALL encode per opcode, with all unlisted bits zero: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100 -> [15:12]=op, [9:8]=rd, [5:4]=ra, [1:0]=rb.
REQ-014 SHALL encode INV 0101 as [15:12]=0101, [9:8]=rd, [5:4]=ra.
REQ-015 SHALL encode INC 1010 and DEC 1011 as [15:12]=op, [9:8]=rd.
REQ-016 SHALL encode LOAD 1000 and JNZ 1110 as [15:12]=op, [9:8]=rd, [7:0]=imm.
REQ-017 SHALL encode JMP 1111 as [15:12]=1111, [7:0]=imm, and HLT 1100 as 0xC000.
REQ-018 SHALL treat opcodes 0110, 0111, 1001 and 1101 as illegal on accept: no write, set err, remain in RUN, count unchanged.
REQ-019 SHALL, after the WRITE of an HLT word, set done and enter STOP.
REQ-020 SHALL assert full when count==DEPTH and enter STOP after that WRITE; done SHALL stay 0 unless the last word written was HLT.
REQ-021 SHALL deassert mem_we in every state except WRITE, and SHALL hold mem_addr/mem_wdata stable while mem_we is high.

Reset
REQ-022 SHALL, on rst=1 at a rising edge, enter IDLE with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, done=0, err=0 and csum=0.
REQ-023 SHALL, when rst is asserted during WRITE, suppress that write in the same cycle; rst SHALL take priority over start and in_valid.

Configuration
REQ-024 SHALL, with INST_WRITER_CSUM_EN defined, update csum to csum XOR mem_wdata on every WRITE cycle.
REQ-025 SHALL, without INST_WRITER_CSUM_EN, tie csum constantly to 0 and contain no accumulator logic.

Verification
REQ-026 SHALL check: start, then LOAD rd=2 imm=0x5A -> one mem_we pulse, addr 0, data 0x825A, count=1.
REQ-027 SHALL check: ADD rd=1 ra=2 rb=3, then JNZ rd=3 imm=0x04 -> data 0x0123 at addr 0 and 0xE304 at addr 1.
REQ-028 SHALL check: in_op=0111 accepted -> no mem_we, err=1, count unchanged; a following INC rd=1 -> data 0xA100.
REQ-029 SHALL check: HLT -> data 0xC000, then done=1, in_ready=0; start -> count=0, done=0, in_ready=1.
REQ-030 SHALL check: 256 back-to-back INC rd=0 words -> full=1, state STOP, done=0, and with CSUM_EN csum=0x0000 (even count of 0xA000).
REQ-031 SHALL check: rst asserted in the WRITE cycle -> no mem_we that cycle, and all outputs at reset values the next cycle.
